// File: rtl/ram_mgr_pkg.sv
// Shared definitions for the RAM-backed min-priority record store and its port arbiter.
// Record layout is key in the upper 32 bits, value in the lower 16 bits.
package ram_mgr_pkg;

    localparam int RECORD_LENGTH = 48;
    localparam int KEY_LENGTH    = 32;
    localparam int KEY_START     = 16;

    typedef logic [RECORD_LENGTH-1:0] record_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_FULL    = 2'b01,
        ST_EMPTY   = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ISSUE  = 2'b01,
        S_SETTLE = 2'b10,
        S_RESP   = 2'b11
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request strictly after
// i_last_grant (wrapping) wins, so the last winner has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDXW-1:0]    o_grant_idx,
    output logic               o_any
);

    logic [IDXW-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = IDXW'((int'(i_last_grant) + off) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single push/pop port of ram_manager between NUM_REQ requesters,
// one operation at a time, with occupancy tracking, reject paths and a settle timeout.
module ram_port_arbiter
    import ram_mgr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_op,
    input  logic [NUM_REQ*RECORD_LENGTH-1:0]    req_record,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [RECORD_LENGTH-1:0]            rsp_record,
    output logic [1:0]                          rsp_status,
    output logic                                push_to_ram,
    output logic [RECORD_LENGTH-1:0]            record_to_push,
    output logic                                pop_from_ram,
    input  logic [RECORD_LENGTH-1:0]            min_record,
    input  logic                                min_valid,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy,
    output logic                                busy,
    output logic                                error
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int OCCW = $clog2(DEPTH + 1);
    localparam int TMRW = $clog2(TIMEOUT + 1);

    logic [NUM_REQ-1:0]       w_gnt;
    logic [IDXW-1:0]          w_gnt_idx;
    logic                     w_any;
    logic                     w_sel_op;
    record_t                  w_sel_record;

    arb_state_t               r_state;
    logic [IDXW-1:0]          r_last_grant;
    logic [NUM_REQ-1:0]       r_gnt;
    logic                     r_op;
    record_t                  r_pop_record;
    logic [TMRW-1:0]          r_timer;
    logic [OCCW-1:0]          r_occupancy;
    logic                     r_error;
    logic [NUM_REQ-1:0]       r_rsp_valid;
    record_t                  r_rsp_record;
    status_t                  r_rsp_status;
    logic                     r_push;
    record_t                  r_record_to_push;
    logic                     r_pop;
    logic                     r_busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_gnt),
        .o_grant_idx  (w_gnt_idx),
        .o_any        (w_any)
    );

    // One-hot mux of the winning requester's op and record
    always_comb begin
        w_sel_op     = 1'b0;
        w_sel_record = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op     = req_op[i];
                w_sel_record = req_record[i*RECORD_LENGTH +: RECORD_LENGTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_last_grant     <= IDXW'(NUM_REQ - 1);
            r_gnt            <= '0;
            r_op             <= 1'b0;
            r_pop_record     <= '0;
            r_timer          <= '0;
            r_occupancy      <= '0;
            r_error          <= 1'b0;
            r_rsp_valid      <= '0;
            r_rsp_record     <= '0;
            r_rsp_status     <= ST_OK;
            r_push           <= 1'b0;
            r_record_to_push <= '0;
            r_pop            <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_rsp_valid  <= '0;
            r_rsp_record <= '0;
            r_rsp_status <= ST_OK;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt_idx;
                        r_op         <= w_sel_op;
                        r_busy       <= 1'b1;
                        if (r_error) begin
                            r_rsp_valid  <= w_gnt;
                            r_rsp_status <= ST_TIMEOUT;
                            r_state      <= S_RESP;
                        end else if (!w_sel_op && r_occupancy == OCCW'(DEPTH)) begin
                            r_rsp_valid  <= w_gnt;
                            r_rsp_status <= ST_FULL;
                            r_state      <= S_RESP;
                        end else if (w_sel_op && r_occupancy == '0) begin
                            r_rsp_valid  <= w_gnt;
                            r_rsp_status <= ST_EMPTY;
                            r_state      <= S_RESP;
                        end else if (w_sel_op) begin
                            // The store is settled while idle, so its minimum is the popped record
                            r_pop_record <= min_record;
                            r_pop        <= 1'b1;
                            r_state      <= S_ISSUE;
                        end else begin
                            r_push           <= 1'b1;
                            r_record_to_push <= w_sel_record;
                            r_state          <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    r_occupancy      <= r_op ? (r_occupancy - 1'b1) : (r_occupancy + 1'b1);
                    r_record_to_push <= '0;
                    r_timer          <= '0;
                    r_state          <= S_SETTLE;
                end

                // Timer value 0 marks the blanking cycle where min_valid is still stale
                S_SETTLE: begin
                    r_timer <= r_timer + 1'b1;
                    if ((r_timer != '0 && min_valid) || (r_timer == '0 && r_occupancy == '0)) begin
                        r_rsp_valid  <= r_gnt;
                        r_rsp_status <= ST_OK;
                        r_rsp_record <= r_op ? r_pop_record : '0;
                        r_state      <= S_RESP;
                    end else if (r_timer == TMRW'(TIMEOUT - 1)) begin
                        r_rsp_valid  <= r_gnt;
                        r_rsp_status <= ST_TIMEOUT;
                        r_error      <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_record     = r_rsp_record;
    assign rsp_status     = r_rsp_status;
    assign push_to_ram    = r_push;
    assign record_to_push = r_record_to_push;
    assign pop_from_ram   = r_pop;
    assign occupancy      = r_occupancy;
    assign busy           = r_busy;
    assign error          = r_error;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a behavioural min-key store drives
// min_record/min_valid, and a queue-based model predicts grants, statuses and records.
module tb_ram_port_arbiter;
    import ram_mgr_pkg::*;

    localparam int NREQ = 4;
    localparam int DEP  = 4;
    localparam int TMO  = 255;
    localparam int RL   = 48;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_op = '0;
    logic [NREQ*RL-1:0] req_record = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [RL-1:0]     rsp_record;
    logic [1:0]        rsp_status;
    logic              push_to_ram;
    logic [RL-1:0]     record_to_push;
    logic              pop_from_ram;
    logic [RL-1:0]     minRec;
    logic              minValid;
    logic [2:0]        occupancy;
    logic              busy;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [RL-1:0] storeQ[$];
    int            settleLeft;
    int            settleDelay = 3;
    bit            holdLow = 1'b0;
    int            pushSeen = 0;
    int            popSeen = 0;
    logic [RL-1:0] lastPushed = '0;

    logic [RL-1:0] modelQ[$];
    int            modelLast = NREQ - 1;
    int            uniq = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .NUM_REQ (NREQ),
        .DEPTH   (DEP),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_record     (req_record),
        .rsp_valid      (rsp_valid),
        .rsp_record     (rsp_record),
        .rsp_status     (rsp_status),
        .push_to_ram    (push_to_ram),
        .record_to_push (record_to_push),
        .pop_from_ram   (pop_from_ram),
        .min_record     (minRec),
        .min_valid      (minValid),
        .occupancy      (occupancy),
        .busy           (busy),
        .error          (error)
    );

    function automatic int queue_min_idx(input logic [RL-1:0] q[$]);
        int best = 0;
        for (int j = 1; j < q.size(); j++)
            if (q[j][47:16] < q[best][47:16]) best = j;
        return best;
    endfunction

    function automatic logic [RL-1:0] queue_min(input logic [RL-1:0] q[$]);
        if (q.size() == 0) return '0;
        return q[queue_min_idx(q)];
    endfunction

    // Behavioural store: drops min_valid on every strobe and raises it settleDelay cycles later
    always @(posedge clk) begin
        if (rst) begin
            storeQ.delete();
            minValid   <= 1'b1;
            settleLeft <= 0;
            minRec     <= '0;
        end else begin
            if (push_to_ram) begin
                storeQ.push_back(record_to_push);
                pushSeen   <= pushSeen + 1;
                lastPushed <= record_to_push;
            end
            if (pop_from_ram) begin
                if (storeQ.size() > 0) storeQ.delete(queue_min_idx(storeQ));
                popSeen <= popSeen + 1;
            end
            if (push_to_ram || pop_from_ram) begin
                minValid   <= 1'b0;
                settleLeft <= settleDelay - 1;
            end else if (settleLeft > 0) begin
                settleLeft <= settleLeft - 1;
                if (settleLeft == 1 && !holdLow) minValid <= 1'b1;
            end else if (!holdLow) begin
                minValid <= 1'b1;
            end
            minRec <= queue_min(storeQ);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelQ.delete();
        modelLast = NREQ - 1;
    endtask

    task automatic set_req(input int idx, input bit op, input logic [RL-1:0] rec);
        req_op[idx] = op;
        req_record[idx*RL +: RL] = rec;
        req_valid[idx] = 1'b1;
    endtask

    function automatic logic [RL-1:0] fresh_record();
        logic [31:0] k;
        logic [15:0] v;
        k = $urandom();
        k[7:0] = uniq[7:0];
        v = 16'($urandom());
        uniq++;
        return {k, v};
    endfunction

    task automatic wait_rsp(input int maxCyc, output logic [NREQ-1:0] v, output logic [RL-1:0] rec,
                            output logic [1:0] st, output int cyc);
        v = '0;
        rec = '0;
        st = '0;
        cyc = -1;
        for (int k = 1; k <= maxCyc; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                v = rsp_valid;
                rec = rsp_record;
                st = rsp_status;
                cyc = k;
                req_valid = req_valid & ~rsp_valid;
                break;
            end
        end
    endtask

    task automatic single_op(input int idx, input bit op, input logic [RL-1:0] recIn, input int maxCyc,
                             output logic [NREQ-1:0] v, output logic [RL-1:0] recOut,
                             output logic [1:0] st, output int cyc);
        @(negedge clk);
        set_req(idx, op, recIn);
        modelLast = idx;
        wait_rsp(maxCyc, v, recOut, st, cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ((|{rsp_valid, rsp_record, rsp_status, push_to_ram, record_to_push,
                   pop_from_ram, occupancy, busy, error}) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got rv=%b st=%b push=%b pop=%b occ=%0d busy=%b err=%b, required all 0",
                         c, rsp_valid, rsp_status, push_to_ram, pop_from_ram, occupancy, busy, error);
            end
        end
    endtask

    task automatic test_reject_empty();
        logic [NREQ-1:0] v;
        logic [RL-1:0] rec;
        logic [1:0] st;
        int cyc, p0, q0;
        p0 = pushSeen;
        q0 = popSeen;
        single_op(1, 1'b1, fresh_record(), 10, v, rec, st, cyc);
        checks++;
        if (v !== 4'b0010) begin errors++; $display("[TB] FAIL reject_empty_valid: got %b required 0010", v); end
        checks++;
        if (st !== 2'b10) begin errors++; $display("[TB] FAIL reject_empty_status: got %b required 10", st); end
        checks++;
        if (rec !== '0) begin errors++; $display("[TB] FAIL reject_empty_record: got %h required 0", rec); end
        checks++;
        if (cyc !== 1) begin errors++; $display("[TB] FAIL reject_empty_latency: got %0d required 1", cyc); end
        checks++;
        if (pushSeen != p0 || popSeen != q0) begin
            errors++;
            $display("[TB] FAIL reject_empty_strobe: got %0d strobes required 0", (pushSeen - p0) + (popSeen - q0));
        end
    endtask

    task automatic test_push_from_empty();
        logic [NREQ-1:0] v;
        logic [RL-1:0] rec;
        logic [1:0] st;
        int cyc, p0;
        settleDelay = 3;
        p0 = pushSeen;
        single_op(2, 1'b0, 48'h00000010AAAA, 20, v, rec, st, cyc);
        modelQ.push_back(48'h00000010AAAA);
        checks++;
        if (v !== 4'b0100) begin errors++; $display("[TB] FAIL push_valid: got %b required 0100", v); end
        checks++;
        if (st !== 2'b00) begin errors++; $display("[TB] FAIL push_status: got %b required 00", st); end
        checks++;
        if (cyc !== 5) begin errors++; $display("[TB] FAIL push_latency: got %0d required 5", cyc); end
        checks++;
        if (pushSeen - p0 != 1) begin errors++; $display("[TB] FAIL push_strobe_count: got %0d required 1", pushSeen - p0); end
        checks++;
        if (lastPushed !== 48'h00000010AAAA) begin
            errors++;
            $display("[TB] FAIL push_record: got %h required 00000010aaaa", lastPushed);
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd1) begin errors++; $display("[TB] FAIL push_occupancy: got %0d required 1", occupancy); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] v;
        logic [RL-1:0] rec;
        logic [1:0] st;
        int cyc, expIdx;
        bit pending[NREQ];
        do_reset();
        settleDelay = 2;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, {32'h00000100 + 32'(i), 16'h1000 + 16'(i)});
            pending[i] = 1'b1;
            modelQ.push_back({32'h00000100 + 32'(i), 16'h1000 + 16'(i)});
        end
        for (int n = 0; n < NREQ; n++) begin
            expIdx = -1;
            for (int off = 1; off <= NREQ && expIdx < 0; off++)
                if (pending[(modelLast + off) % NREQ]) expIdx = (modelLast + off) % NREQ;
            wait_rsp(30, v, rec, st, cyc);
            checks++;
            if (v !== NREQ'(1 << expIdx)) begin
                errors++;
                $display("[TB] FAIL rr_order #%0d: got %b required %b", n, v, NREQ'(1 << expIdx));
            end
            checks++;
            if (st !== 2'b00 || cyc !== (n == 0 ? 4 : 5)) begin
                errors++;
                $display("[TB] FAIL rr_status_spacing #%0d: got st=%b cyc=%0d required st=00 cyc=%0d",
                         n, st, cyc, (n == 0 ? 4 : 5));
            end
            pending[expIdx] = 1'b0;
            modelLast = expIdx;
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd4 || rsp_valid !== '0) begin
            errors++;
            $display("[TB] FAIL rr_occupancy: got occ=%0d rv=%b required occ=4 rv=0000", occupancy, rsp_valid);
        end
    endtask

    task automatic test_full();
        logic [NREQ-1:0] v;
        logic [RL-1:0] rec, expRec;
        logic [1:0] st;
        int cyc, p0, q0, mi;
        p0 = pushSeen;
        single_op(0, 1'b0, 48'h000000050005, 10, v, rec, st, cyc);
        checks++;
        if (v !== 4'b0001 || st !== 2'b01 || cyc !== 1) begin
            errors++;
            $display("[TB] FAIL full_reject: got rv=%b st=%b cyc=%0d required rv=0001 st=01 cyc=1", v, st, cyc);
        end
        checks++;
        if (pushSeen != p0) begin errors++; $display("[TB] FAIL full_strobe: got %0d pushes required 0", pushSeen - p0); end
        q0 = popSeen;
        mi = queue_min_idx(modelQ);
        expRec = modelQ[mi];
        modelQ.delete(mi);
        single_op(3, 1'b1, '0, 20, v, rec, st, cyc);
        checks++;
        if (v !== 4'b1000 || st !== 2'b00) begin
            errors++;
            $display("[TB] FAIL full_pop_status: got rv=%b st=%b required rv=1000 st=00", v, st);
        end
        checks++;
        if (rec !== expRec) begin errors++; $display("[TB] FAIL full_pop_record: got %h required %h", rec, expRec); end
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd3 || popSeen - q0 != 1) begin
            errors++;
            $display("[TB] FAIL full_pop_occupancy: got occ=%0d pops=%0d required occ=3 pops=1", occupancy, popSeen - q0);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v, mask;
        logic [RL-1:0] rec, expRec;
        logic [1:0] st, expSt;
        int cyc, expIdx, mi, basePush, basePop, expPush, expPop, n;
        bit pending[NREQ];
        bit reqOp[NREQ];
        logic [RL-1:0] reqRec[NREQ];
        basePush = pushSeen;
        basePop = popSeen;
        expPush = 0;
        expPop = 0;
        for (int b = 0; b < 40; b++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            settleDelay = $urandom_range(2, 5);
            @(negedge clk);
            n = 0;
            for (int i = 0; i < NREQ; i++) begin
                pending[i] = mask[i];
                if (mask[i]) begin
                    reqOp[i] = 1'($urandom_range(0, 1));
                    reqRec[i] = fresh_record();
                    set_req(i, reqOp[i], reqRec[i]);
                    n++;
                end
            end
            for (int r = 0; r < n; r++) begin
                expIdx = -1;
                for (int off = 1; off <= NREQ && expIdx < 0; off++)
                    if (pending[(modelLast + off) % NREQ]) expIdx = (modelLast + off) % NREQ;
                expRec = '0;
                if (!reqOp[expIdx] && modelQ.size() == DEP) begin
                    expSt = 2'b01;
                end else if (reqOp[expIdx] && modelQ.size() == 0) begin
                    expSt = 2'b10;
                end else if (reqOp[expIdx]) begin
                    expSt = 2'b00;
                    mi = queue_min_idx(modelQ);
                    expRec = modelQ[mi];
                    modelQ.delete(mi);
                    expPop++;
                end else begin
                    expSt = 2'b00;
                    modelQ.push_back(reqRec[expIdx]);
                    expPush++;
                end
                wait_rsp(40, v, rec, st, cyc);
                checks++;
                if (v !== NREQ'(1 << expIdx) || st !== expSt || rec !== expRec) begin
                    errors++;
                    $display("[TB] FAIL random b%0d r%0d: got rv=%b st=%b rec=%h required rv=%b st=%b rec=%h",
                             b, r, v, st, rec, NREQ'(1 << expIdx), expSt, expRec);
                end
                pending[expIdx] = 1'b0;
                modelLast = expIdx;
            end
            @(negedge clk);
            checks++;
            if (occupancy !== 3'(modelQ.size()) || (pushSeen - basePush) != expPush || (popSeen - basePop) != expPop) begin
                errors++;
                $display("[TB] FAIL random_occupancy b%0d: got occ=%0d push=%0d pop=%0d required occ=%0d push=%0d pop=%0d",
                         b, occupancy, pushSeen - basePush, popSeen - basePop, modelQ.size(), expPush, expPop);
            end
        end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] v;
        logic [RL-1:0] rec;
        logic [1:0] st;
        int cyc, p0, q0;
        do_reset();
        settleDelay = 3;
        holdLow = 1'b1;
        single_op(0, 1'b0, fresh_record(), 300, v, rec, st, cyc);
        checks++;
        if (v !== 4'b0001 || st !== 2'b11 || rec !== '0) begin
            errors++;
            $display("[TB] FAIL timeout_status: got rv=%b st=%b rec=%h required rv=0001 st=11 rec=0", v, st, rec);
        end
        checks++;
        if (cyc !== TMO + 2) begin errors++; $display("[TB] FAIL timeout_latency: got %0d required %0d", cyc, TMO + 2); end
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || occupancy !== 3'd1) begin
            errors++;
            $display("[TB] FAIL timeout_error_flag: got err=%b occ=%0d required err=1 occ=1", error, occupancy);
        end
        holdLow = 1'b0;
        p0 = pushSeen;
        q0 = popSeen;
        single_op(1, 1'b1, '0, 10, v, rec, st, cyc);
        checks++;
        if (v !== 4'b0010 || st !== 2'b11 || cyc !== 1 || pushSeen != p0 || popSeen != q0) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got rv=%b st=%b cyc=%0d strobes=%0d required rv=0010 st=11 cyc=1 strobes=0",
                     v, st, cyc, (pushSeen - p0) + (popSeen - q0));
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("[TB] FAIL timeout_clear: got err=%b occ=%0d required err=0 occ=0", error, occupancy);
        end
    endtask

    initial begin
        $display("[TB] starting ram_port_arbiter bench");
        test_reset();
        test_reject_empty();
        test_push_from_empty();
        test_round_robin();
        test_full();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single push/pop port of the RAM-backed min-priority record store (`ram_manager`) between `NUM_REQ` independent requesters. Grants one operation at a time in round-robin order, sequences the push/pop handshake against `min_valid`, and tracks queue occupancy. Rejects pushes to a full store and pops from an empty store without touching it. Enforces a settle timeout on every issued operation. Sits directly in front of `ram_manager`; requesters never drive its port directly.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DEPTH`, 64: store capacity in records.
- `TIMEOUT`, 255: max SETTLE cycles before error.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request; held high until that requester's `rsp_valid`.
- `req_op` in `NUM_REQ`: 1 = pop, 0 = push.
- `req_record` in `NUM_REQ*48`: push records; requester i at bits [48*i+47:48*i]; key [47:16], value [15:0].
- `rsp_valid` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `rsp_record` out 48: popped record; 0 for push or reject.
- `rsp_status` out 2: 00 ok, 01 full, 10 empty, 11 timeout.
- `push_to_ram` out 1: one-cycle push strobe.
- `record_to_push` out 48: record presented with `push_to_ram`.
- `pop_from_ram` out 1: one-cycle pop strobe.
- `min_record` in 48: current minimum record from the store.
- `min_valid` in 1: store settled and `min_record` valid.
- `occupancy` out clog2(`DEPTH`+1): records currently stored.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky timeout flag, cleared only by `rst`.

## Operation
- States: IDLE, ISSUE, SETTLE, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If any `req_valid` is set, grant via round-robin, searching from `last_grant+1` upward with wrap.
  - Latch granted index g, op and record, then set `last_grant`=g.
  - If `error`, go to RESP with status 11.
  - Push with `occupancy`==`DEPTH`: go to RESP, status 01.
  - Pop with `occupancy`==0: go to RESP, status 10.
  - Pop otherwise: capture `min_record` into the response register (store is settled in IDLE), go to ISSUE.
  - Push otherwise: go to ISSUE.
- ISSUE:
  - Exactly one cycle.
  - Drive `push_to_ram`=1 with `record_to_push`=latched record, or drive `pop_from_ram`=1.
  - `occupancy` increments on push, decrements on pop, at the end of this cycle.
  - Go to SETTLE.
- SETTLE:
  - The first SETTLE cycle ignores `min_valid` (blanking for the store's own deassert).
  - From the second cycle on, `min_valid`=1 moves to RESP with status 00.
  - If the new `occupancy`==0, go to RESP after the blank cycle without waiting for `min_valid`.
  - The timeout counter counts SETTLE cycles; at `TIMEOUT` go to RESP with status 11 and set `error`.
- RESP:
  - `rsp_valid[g]`=1 for one cycle with `rsp_record`/`rsp_status`.
  - Go to IDLE.
- Requesters deassert `req_valid` on the edge that samples their `rsp_valid`.
- Requester-side changes after grant are ignored.

## Timing
- Reset values:
  - All outputs 0: `rsp_*`, strobes, `record_to_push`, `occupancy`, `busy`, `error`.
  - State IDLE; `last_grant`=`NUM_REQ`-1, so requester 0 wins first; timeout counter 0.
- Reject latency: grant in cycle t, `rsp_valid` in t+1.
- Ok latency: ISSUE in t+1, SETTLE from t+2, earliest `rsp_valid` at t+4. Each extra cycle of `min_valid` low adds one.
- Back-to-back: a new grant is possible in the IDLE cycle directly after RESP. Minimum 2-cycle spacing for rejects, 5 cycles for ok operations.
- Simultaneous requests: exactly one grant per IDLE; losers stay pending; no starvation (max wait `NUM_REQ`-1 operations).
- `rst` asserted in any state returns to IDLE next edge. No strobe or `rsp_valid` is emitted in the reset cycle; in-flight operations are dropped without response.

## Structure
- Shared package `ram_mgr_pkg`:
  - RECORD_LENGTH=48, KEY_LENGTH=32, KEY_START=16.
  - Status codes ST_OK, ST_FULL, ST_EMPTY, ST_TIMEOUT.
  - Arbiter state encoding.
- Sub-module `rr_arbiter`: combinational round-robin picker. Takes request vector and `last_grant`, outputs one-hot grant and index. Instantiated once.

## Test plan
- Reset then idle: all outputs 0, `occupancy`=0, `busy`=0 for 10 cycles.
- Push from empty: requester 2 pushes key 0x00000010 value 0xAAAA, model raises `min_valid` 3 cycles after strobe. Expect one `push_to_ram` pulse carrying 0x00000010AAAA, `occupancy`=1, `rsp_valid`=0b0100, status 00.
- Reject on empty: requester 1 pops with `occupancy`=0. Expect no strobe, `rsp_valid`=0b0010 one cycle after grant, status 10, `rsp_record`=0.
- Round-robin: all 4 requesters push simultaneously after reset. Expect grants in order 0,1,2,3 and `occupancy`=4.
- Full store: `DEPTH`=4, fill, then fifth push gives status 01 with no strobe. A following pop returns the model's minimum record and `occupancy`=3.
- Timeout: model holds `min_valid`=0 after a push. Expect status 11 after 255 SETTLE cycles and `error`=1. The next request gets status 11 without a strobe. `rst` clears `error`.
